// File: rtl/serial_frame_rx.sv
// serial_frame_rx: parametrised serial frame receiver with optional parity, stop check and valid/ready holding register.
// Define SFR_MSB_FIRST_EN to receive data MSB first; LSB first otherwise.
module serial_frame_rx #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SAMPLE_EN,
  input  logic              SDATA,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              VALID,
  input  logic              READY,
  output logic              PAR_ERR,
  output logic              FRAME_ERR,
  output logic              OVERRUN,
  output logic              BUSY
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sh, sh_n;
  logic par_bit, par_err_n, done, free;
`ifdef SFR_MSB_FIRST_EN
  assign sh_n = (sh << 1) | DATA_W'(SDATA);
`else
  assign sh_n = (sh >> 1) | (DATA_W'(SDATA) << (DATA_W - 1));
`endif
  assign par_err_n = (PARITY_MODE == 0) ? 1'b0 : (PARITY_MODE == 2) ? ~^{sh, par_bit} : ^{sh, par_bit};
  assign done = SAMPLE_EN && (state == STOP);
  assign free = !VALID || READY;
  assign BUSY = (state != IDLE);
  // state register
  always_ff @(posedge CLK)
    state <= !RST ? IDLE : state_n;
  // next state, only evaluated on sample strobes
  always_comb begin
    state_n = state;
    if (SAMPLE_EN)
      case (state)
        IDLE:    state_n = SDATA ? IDLE : DATA;
        DATA:    state_n = (cnt == CW'(DATA_W - 1)) ? ((PARITY_MODE != 0) ? PARITY : STOP) : DATA;
        PARITY:  state_n = STOP;
        default: state_n = SDATA ? IDLE : WAIT_IDLE;
      endcase
  end
  // bit counter, shift register and parity capture
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt     <= '0;
      sh      <= '0;
      par_bit <= 1'b0;
    end else if (SAMPLE_EN) begin
      if (state == IDLE) cnt <= '0;
      if (state == DATA) begin
        sh  <= sh_n;
        cnt <= cnt + CW'(1);
      end
      if (state == PARITY) par_bit <= SDATA;
    end
  end
  // holding register: load on completion when free, drop with overrun pulse otherwise
  always_ff @(posedge CLK) begin
    if (!RST) begin
      DATA_OUT  <= '0;
      VALID     <= 1'b0;
      PAR_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OVERRUN <= done && !free;
      if (done && free) begin
        DATA_OUT  <= sh;
        PAR_ERR   <= par_err_n;
        FRAME_ERR <= ~SDATA;
        VALID     <= 1'b1;
      end else if (VALID && READY) begin
        VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx (DATA_W=8, even and odd parity instances).
module tb_serial_frame_rx;
  logic CLK = 1'b0, RST = 1'b0, SAMPLE_EN = 1'b0, SDATA = 1'b1, READY = 1'b0;
  logic [7:0] DATA_OUT, o_data;
  logic VALID, PAR_ERR, FRAME_ERR, OVERRUN, BUSY;
  logic o_valid, o_par, o_frame, o_ovr, o_busy;
  int n_vec = 0, n_err = 0;
  logic [9:0] sb[$];
  always #5 CLK = ~CLK;
  serial_frame_rx #(.DATA_W(8), .PARITY_MODE(1)) dut (
    .CLK(CLK), .RST(RST), .SAMPLE_EN(SAMPLE_EN), .SDATA(SDATA), .DATA_OUT(DATA_OUT), .VALID(VALID),
    .READY(READY), .PAR_ERR(PAR_ERR), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY));
  serial_frame_rx #(.DATA_W(8), .PARITY_MODE(2)) dut_odd (
    .CLK(CLK), .RST(RST), .SAMPLE_EN(SAMPLE_EN), .SDATA(SDATA), .DATA_OUT(o_data), .VALID(o_valid),
    .READY(READY), .PAR_ERR(o_par), .FRAME_ERR(o_frame), .OVERRUN(o_ovr), .BUSY(o_busy));

  task automatic send_bit(input logic b, input logic rdy);
    SDATA = b;
    SAMPLE_EN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 SAMPLE_EN = 1'b1;
    READY = rdy;
    @(posedge CLK);
    #1 SAMPLE_EN = 1'b0;
    READY = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic pflip, input logic stop, input logic push, input logic rdy_stop);
    logic p;
    p = ^w ^ pflip;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
`ifdef SFR_MSB_FIRST_EN
      send_bit(w[7-i], 1'b0);
`else
      send_bit(w[i], 1'b0);
`endif
    end
    send_bit(p, 1'b0);
    send_bit(stop, rdy_stop);
    if (push) sb.push_back({w, pflip, ~stop});
  endtask

  task automatic consume(input string tag);
    logic [9:0] e;
    int t;
    t = 0;
    while (VALID !== 1'b1 && t < 100) begin
      @(posedge CLK);
      #1 t++;
    end
    n_vec++;
    if (VALID !== 1'b1 || sb.size() == 0) begin
      n_err++;
      $display("FAIL %s_valid: VALID=%b queued=%0d, required VALID=1 with a queued frame", tag, VALID, sb.size());
    end else begin
      e = sb.pop_front();
      n_vec++;
      if ({DATA_OUT, PAR_ERR, FRAME_ERR} !== e) begin
        n_err++;
        $display("FAIL %s_frame: data=%h par=%b frm=%b, required data=%h par=%b frm=%b", tag, DATA_OUT, PAR_ERR, FRAME_ERR, e[9:2], e[1], e[0]);
      end
      READY = 1'b1;
      @(posedge CLK);
      #1 READY = 1'b0;
      n_vec++;
      if (VALID !== 1'b0) begin
        n_err++;
        $display("FAIL %s_release: VALID=%b, required 0", tag, VALID);
      end
    end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 n_vec++;
    if ({DATA_OUT, VALID, PAR_ERR, FRAME_ERR, OVERRUN, BUSY} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: %h %b %b %b %b %b, required all 0", DATA_OUT, VALID, PAR_ERR, FRAME_ERR, OVERRUN, BUSY);
    end
    RST = 1'b1;
  endtask

  task automatic test_basic;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (BUSY !== 1'b0) begin n_err++; $display("FAIL basic_busy: BUSY=%b, required 0", BUSY); end
    consume("basic");
    n_vec++;
    if (DATA_OUT !== 8'hA5) begin n_err++; $display("FAIL basic_hold: DATA_OUT=%h, required a5", DATA_OUT); end
  endtask

  task automatic test_parity;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({o_valid, o_par, o_data} !== {1'b1, 1'b0, 8'hA5}) begin
      n_err++;
      $display("FAIL parity_odd: valid=%b par=%b data=%h, required 1 0 a5", o_valid, o_par, o_data);
    end
    consume("parity_even");
  endtask

  task automatic test_frame_err;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({VALID, FRAME_ERR, BUSY} !== 3'b111) begin
      n_err++;
      $display("FAIL frame_stop: valid=%b frm=%b busy=%b, required 1 1 1", VALID, FRAME_ERR, BUSY);
    end
    for (int i = 0; i < 2; i++) begin
      send_bit(1'b0, 1'b0);
      n_vec++;
      if (BUSY !== 1'b1) begin n_err++; $display("FAIL frame_wait%0d: BUSY=%b, required 1", i, BUSY); end
    end
    send_bit(1'b1, 1'b0);
    n_vec++;
    if ({BUSY, OVERRUN} !== 2'b00) begin
      n_err++;
      $display("FAIL frame_idle: busy=%b ovr=%b, required 0 0", BUSY, OVERRUN);
    end
    consume("frame");
  endtask

  task automatic test_overrun;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++;
    if (OVERRUN !== 1'b1) begin n_err++; $display("FAIL overrun_pulse: OVERRUN=%b, required 1", OVERRUN); end
    @(posedge CLK);
    #1 n_vec++;
    if ({OVERRUN, VALID, DATA_OUT} !== {1'b0, 1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL overrun_hold: ovr=%b valid=%b data=%h, required 0 1 11", OVERRUN, VALID, DATA_OUT);
    end
    consume("overrun");
  endtask

  task automatic test_back_to_back;
    logic [9:0] e;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    e = sb.pop_front();
    n_vec++;
    if ({VALID, DATA_OUT, PAR_ERR, FRAME_ERR} !== {1'b1, e}) begin
      n_err++;
      $display("FAIL b2b_first: valid=%b data=%h, required 1 %h", VALID, DATA_OUT, e[9:2]);
    end
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ({OVERRUN, VALID, DATA_OUT} !== {1'b0, 1'b1, 8'h22}) begin
      n_err++;
      $display("FAIL b2b_load: ovr=%b valid=%b data=%h, required 0 1 22", OVERRUN, VALID, DATA_OUT);
    end
    consume("b2b");
  endtask

  task automatic test_reset_midframe;
    send_frame(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    RST = 1'b0;
    @(posedge CLK);
    #1 n_vec++;
    if ({DATA_OUT, VALID, PAR_ERR, FRAME_ERR, OVERRUN, BUSY, o_data, o_valid, o_par, o_frame, o_ovr, o_busy} !== 26'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: data=%h valid=%b busy=%b odd_data=%h odd_valid=%b, required all 0", DATA_OUT, VALID, BUSY, o_data, o_valid);
    end
    @(posedge CLK);
    #1 RST = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
    consume("midreset");
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    consume("rerun");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    n_vec++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
